// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score board: FSM states, BCD digits,
// and the DE2 active-low seven-segment encoding.
package pong_pkg;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } score_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, active low.
    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic score_t bcd_inc(score_t s);
        score_t r;
        if (s.units == 4'd9) begin
            r.tens  = s.tens + 4'd1;
            r.units = 4'd0;
        end else begin
            r.tens  = s.tens;
            r.units = s.units + 4'd1;
        end
        return r;
    endfunction

    function automatic score_t to_bcd(int unsigned v);
        score_t r;
        r.tens  = 4'(v / 10);
        r.units = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/pong_bcd_to_seg.sv
// One BCD digit to active-low seven-segment pattern, with a forced-blank input.
module pong_bcd_to_seg
    import pong_pkg::*;
(
    input  bcd_t       digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && digit <= 4'd9) begin
            seg = SEG_DIGITS[digit];
        end
    end

endmodule

// File: rtl/pong_score_board.sv
// Two-player BCD score keeper with match-end detection and HEX display drive.
// Optional feature macro SCORE_FLASH_EN: flash the winner's digits while OVER.
module pong_score_board
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE = 11,
    parameter int unsigned FLASH_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       point_left,
    input  logic       point_right,
    input  logic       new_match,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic [6:0] hex6,
    output logic [6:0] hex7,
    output logic       game_over,
    output logic       winner
);

    if (WIN_SCORE < 1 || WIN_SCORE > 99) begin : g_bad_win_score
        $error("WIN_SCORE must be in 1..99");
    end
    if (FLASH_DIV < 2) begin : g_bad_flash_div
        $error("FLASH_DIV must be at least 2");
    end

    localparam score_t WIN_BCD = to_bcd(WIN_SCORE);

    state_e state_q, state_d;
    score_t score_l_q, score_l_d, score_r_q, score_r_d;
    score_t nxt_l, nxt_r;
    logic   winner_q, winner_d;

    always_comb begin
        nxt_l     = point_left  ? bcd_inc(score_l_q) : score_l_q;
        nxt_r     = point_right ? bcd_inc(score_r_q) : score_r_q;
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        if (new_match) begin
            state_d   = ST_PLAY;
            score_l_d = '0;
            score_r_d = '0;
            winner_d  = 1'b0;
        end else if (state_q == ST_PLAY) begin
            score_l_d = nxt_l;
            score_r_d = nxt_r;
            if (nxt_l == WIN_BCD || nxt_r == WIN_BCD) begin
                state_d  = ST_OVER;
                // A tie on the winning point goes to the left player.
                winner_d = (nxt_r == WIN_BCD) && (nxt_l != WIN_BCD);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PLAY;
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            winner_q  <= winner_d;
        end
    end

    assign game_over = (state_q == ST_OVER);
    assign winner    = winner_q;

    logic flash_hide;

`ifdef SCORE_FLASH_EN
    localparam int unsigned CNT_W = $clog2(FLASH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_DIV - 1);

    logic [CNT_W-1:0] flash_cnt_q;
    logic             flash_vis_q;

    // Held at zero/visible outside OVER, so counting starts fresh on entry.
    always_ff @(posedge clk) begin
        if (rst || state_q != ST_OVER) begin
            flash_cnt_q <= '0;
            flash_vis_q <= 1'b1;
        end else if (flash_cnt_q == CNT_LAST) begin
            flash_cnt_q <= '0;
            flash_vis_q <= ~flash_vis_q;
        end else begin
            flash_cnt_q <= flash_cnt_q + 1'b1;
        end
    end

    assign flash_hide = (state_q == ST_OVER) && !flash_vis_q;
`else
    assign flash_hide = 1'b0;
`endif

    logic       hide_l, hide_r;
    logic [6:0] seg_lt, seg_lu, seg_rt, seg_ru;

    assign hide_l = flash_hide && !winner_q;
    assign hide_r = flash_hide && winner_q;

    pong_bcd_to_seg u_seg_lt (
        .digit (score_l_q.tens),
        .blank (hide_l || score_l_q.tens == 4'd0),
        .seg   (seg_lt)
    );
    pong_bcd_to_seg u_seg_lu (
        .digit (score_l_q.units),
        .blank (hide_l),
        .seg   (seg_lu)
    );
    pong_bcd_to_seg u_seg_rt (
        .digit (score_r_q.tens),
        .blank (hide_r || score_r_q.tens == 4'd0),
        .seg   (seg_rt)
    );
    pong_bcd_to_seg u_seg_ru (
        .digit (score_r_q.units),
        .blank (hide_r),
        .seg   (seg_ru)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hex7 <= SEG_BLANK;
            hex6 <= SEG_DIGITS[0];
            hex1 <= SEG_BLANK;
            hex0 <= SEG_DIGITS[0];
        end else begin
            hex7 <= seg_lt;
            hex6 <= seg_lu;
            hex1 <= seg_rt;
            hex0 <= seg_ru;
        end
    end

    assign hex2 = SEG_BLANK;
    assign hex3 = SEG_BLANK;
    assign hex4 = SEG_BLANK;
    assign hex5 = SEG_BLANK;

endmodule

// File: tb/tb_pong_score_board.sv
// Bench for pong_score_board: two instances (WIN_SCORE 11 and 3) share stimulus
// and are checked against an integer-level model of the scoring rules.
module tb_pong_score_board;

    localparam int FDIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, point_left, point_right, new_match;
    logic [6:0] a_hex [8];
    logic [6:0] b_hex [8];
    logic       a_go, a_win, b_go, b_win;

    pong_score_board #(.WIN_SCORE(11), .FLASH_DIV(FDIV)) dut_a (
        .clk(clk), .rst(rst), .point_left(point_left), .point_right(point_right),
        .new_match(new_match),
        .hex0(a_hex[0]), .hex1(a_hex[1]), .hex2(a_hex[2]), .hex3(a_hex[3]),
        .hex4(a_hex[4]), .hex5(a_hex[5]), .hex6(a_hex[6]), .hex7(a_hex[7]),
        .game_over(a_go), .winner(a_win)
    );

    pong_score_board #(.WIN_SCORE(3), .FLASH_DIV(FDIV)) dut_b (
        .clk(clk), .rst(rst), .point_left(point_left), .point_right(point_right),
        .new_match(new_match),
        .hex0(b_hex[0]), .hex1(b_hex[1]), .hex2(b_hex[2]), .hex3(b_hex[3]),
        .hex4(b_hex[4]), .hex5(b_hex[5]), .hex6(b_hex[6]), .hex7(b_hex[7]),
        .game_over(b_go), .winner(b_win)
    );

    int total = 0;
    int bad = 0;

    // Reference model: plain integer scores per instance.
    int   win_score [2] = '{11, 3};
    int   sl [2], sr [2], oc [2];
    bit   over [2], wnr [2];
    logic [6:0] exp_hex [2][4];   // hex7, hex6, hex1, hex0
    bit   hex_known = 1'b0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] digit_seg(int d, bit blank);
        return blank ? 7'h7F : seg_tab[d];
    endfunction

    task automatic check(string name, logic [6:0] act, logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(bit r, bit pl, bit pr, bit nm);
        for (int d = 0; d < 2; d++) begin
            bit vis = 1'b1;
            bit hl, hr;
`ifdef SCORE_FLASH_EN
            if (over[d] && ((oc[d] / FDIV) % 2 == 1)) vis = 1'b0;
`endif
            hl = over[d] && !wnr[d] && !vis;
            hr = over[d] && wnr[d] && !vis;
            exp_hex[d][0] = digit_seg(sl[d] / 10, (sl[d] / 10 == 0) || hl);
            exp_hex[d][1] = digit_seg(sl[d] % 10, hl);
            exp_hex[d][2] = digit_seg(sr[d] / 10, (sr[d] / 10 == 0) || hr);
            exp_hex[d][3] = digit_seg(sr[d] % 10, hr);
            if (r || nm) begin
                sl[d] = 0; sr[d] = 0; over[d] = 0; wnr[d] = 0; oc[d] = 0;
            end else if (!over[d]) begin
                sl[d] += int'(pl);
                sr[d] += int'(pr);
                if (sl[d] == win_score[d] || sr[d] == win_score[d]) begin
                    over[d] = 1'b1;
                    wnr[d]  = (sr[d] == win_score[d]) && (sl[d] != win_score[d]);
                    oc[d]   = 0;
                end
            end else begin
                oc[d]++;
            end
        end
        hex_known = !r;
    endtask

    task automatic check_model();
        check("a_game_over", 7'(a_go), 7'(over[0]));
        check("a_winner", 7'(a_win), 7'(wnr[0]));
        check("b_game_over", 7'(b_go), 7'(over[1]));
        check("b_winner", 7'(b_win), 7'(wnr[1]));
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("a_hex%0d", i), a_hex[i], 7'h7F);
            check($sformatf("b_hex%0d", i), b_hex[i], 7'h7F);
        end
        if (hex_known) begin
            check("a_hex7", a_hex[7], exp_hex[0][0]);
            check("a_hex6", a_hex[6], exp_hex[0][1]);
            check("a_hex1", a_hex[1], exp_hex[0][2]);
            check("a_hex0", a_hex[0], exp_hex[0][3]);
            check("b_hex7", b_hex[7], exp_hex[1][0]);
            check("b_hex6", b_hex[6], exp_hex[1][1]);
            check("b_hex1", b_hex[1], exp_hex[1][2]);
            check("b_hex0", b_hex[0], exp_hex[1][3]);
        end
    endtask

    task automatic step(bit r, bit pl, bit pr, bit nm);
        rst = r; point_left = pl; point_right = pr; new_match = nm;
        @(posedge clk);
        model_edge(r, pl, pr, nm);
        #1;
        check_model();
    endtask

    typedef struct {
        bit         pl, pr, nm;
        bit         go, win;
        logic [6:0] h7, h6, h1, h0;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Expected dut_b (WIN_SCORE=3) outputs after each row's edge.
        tbl[0]  = '{1, 0, 0, 0, 0, 7'h7F, 7'h40, 7'h7F, 7'h40};
        tbl[0]  = '{0, 1, 0, 0, 0, 7'h7F, 7'h40, 7'h7F, 7'h40};
        tbl[1]  = '{0, 1, 0, 0, 0, 7'h7F, 7'h40, 7'h7F, 7'h79};
        tbl[2]  = '{0, 1, 0, 1, 1, 7'h7F, 7'h40, 7'h7F, 7'h24};
        tbl[3]  = '{0, 1, 0, 1, 1, 7'h7F, 7'h40, 7'h7F, 7'h30};
        tbl[4]  = '{1, 0, 1, 0, 0, 7'h7F, 7'h40, 7'h7F, 7'h30};
        tbl[5]  = '{0, 0, 0, 0, 0, 7'h7F, 7'h40, 7'h7F, 7'h40};
        tbl[6]  = '{1, 1, 0, 0, 0, 7'h7F, 7'h40, 7'h7F, 7'h40};
        tbl[7]  = '{1, 1, 0, 0, 0, 7'h7F, 7'h79, 7'h7F, 7'h79};
        tbl[8]  = '{1, 1, 0, 1, 0, 7'h7F, 7'h24, 7'h7F, 7'h24};
        tbl[9]  = '{0, 0, 0, 1, 0, 7'h7F, 7'h30, 7'h7F, 7'h30};
        tbl[10] = '{0, 0, 1, 0, 0, 7'h7F, 7'h30, 7'h7F, 7'h30};
        tbl[11] = '{0, 0, 0, 0, 0, 7'h7F, 7'h40, 7'h7F, 7'h40};

        rst = 1'b1; point_left = 1'b0; point_right = 1'b0; new_match = 1'b0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("reset_hex6", b_hex[6], 7'h40);
        check("reset_hex0", b_hex[0], 7'h40);
        check("reset_hex7", b_hex[7], 7'h7F);
        check("reset_go", 7'(b_go), 7'h00);

        for (int i = 0; i < 12; i++) begin
            step(0, tbl[i].pl, tbl[i].pr, tbl[i].nm);
            check($sformatf("tbl%0d_go", i), 7'(b_go), 7'(tbl[i].go));
            check($sformatf("tbl%0d_win", i), 7'(b_win), 7'(tbl[i].win));
            check($sformatf("tbl%0d_hex7", i), b_hex[7], tbl[i].h7);
            check($sformatf("tbl%0d_hex6", i), b_hex[6], tbl[i].h6);
            check($sformatf("tbl%0d_hex1", i), b_hex[1], tbl[i].h1);
            check($sformatf("tbl%0d_hex0", i), b_hex[0], tbl[i].h0);
        end

        // Ten left points on the WIN_SCORE=11 instance: BCD carry to "10".
        step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("ten_hex7", a_hex[7], 7'h79);
        check("ten_hex6", a_hex[6], 7'h40);
        check("ten_go", 7'(a_go), 7'h00);
        step(0, 1, 1, 0);
        check("eleven_go", 7'(a_go), 7'h01);
        check("eleven_win", 7'(a_win), 7'h00);
        // Left has won: watch the flash window (model checks every cycle).
        for (int i = 0; i < 20; i++) step(0, i % 3 == 0, 1, 0);
        check("frozen_hex1", a_hex[1], 7'h7F);
        check("frozen_hex0", a_hex[0], 7'h79);

        // Over-state new_match together with a point: point dropped.
        step(0, 1, 0, 1);
        check("nm_go", 7'(a_go), 7'h00);
        step(0, 0, 0, 0);
        check("nm_hex6", a_hex[6], 7'h40);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
